// File: rtl/mult_pkg.sv
// Shared definitions for the shift-add multiplier: FSM state encoding and counter sizing.
package mult_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_DONE = 2'd2
    } mult_state_e;

    // Ceiling log2 for elaboration-time sizing; returns 0 for value <= 1.
    function automatic int unsigned clog2(input int unsigned value);
        int unsigned r;
        r = 0;
        for (int i = 0; i < 32; i++) begin
            if ((64'd1 << i) < 64'(value)) begin
                r = 32'(i) + 1;
            end
        end
        return r;
    endfunction

    // The step counter must be able to hold 0..width.
    function automatic int unsigned cnt_width(input int unsigned width);
        return clog2(width + 1);
    endfunction

endpackage

// File: rtl/shift_add_datapath.sv
// Accumulator, shifted multiplicand and multiplier registers with the shift-add adder.
// Signed operand handling is built only when MULT_SIGNED_EN is defined.
module shift_add_datapath
    import mult_pkg::*;
#(
    parameter int unsigned WIDTH = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               load,
    input  logic               step,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    input  logic               signed_mode,
    output logic [2*WIDTH-1:0] prod_c
);

    localparam int unsigned PW = 2 * WIDTH;

    logic [PW-1:0]    acc_q;
    logic [PW-1:0]    mcand_q;
    logic [WIDTH-1:0] mplier_q;
    logic [PW-1:0]    acc_nxt;
    logic [WIDTH-1:0] a_mag;
    logic [WIDTH-1:0] b_mag;

    // Accumulator value after the current step; on the last step this is the magnitude product.
    always_comb begin
        acc_nxt = acc_q + (mplier_q[0] ? mcand_q : '0);
    end

`ifdef MULT_SIGNED_EN
    logic neg_q;
    logic neg_nxt;

    // Magnitudes as WIDTH-bit unsigned values, so the most-negative operand maps to 2**(WIDTH-1).
    always_comb begin
        a_mag   = (signed_mode && a[WIDTH-1]) ? (~a + WIDTH'(1)) : a;
        b_mag   = (signed_mode && b[WIDTH-1]) ? (~b + WIDTH'(1)) : b;
        neg_nxt = signed_mode && (a[WIDTH-1] ^ b[WIDTH-1]);
        prod_c  = neg_q ? (~acc_nxt + PW'(1)) : acc_nxt;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            neg_q <= 1'b0;
        end else if (load) begin
            neg_q <= neg_nxt;
        end
    end
`else
    logic unused_signed;

    assign unused_signed = signed_mode;
    assign a_mag         = a;
    assign b_mag         = b;
    assign prod_c        = acc_nxt;
`endif

    // Load clears the accumulator; each step adds and shifts one multiplier bit.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_q    <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
        end else if (load) begin
            acc_q    <= '0;
            mcand_q  <= PW'(a_mag);
            mplier_q <= b_mag;
        end else if (step) begin
            acc_q    <= acc_nxt;
            mcand_q  <= mcand_q << 1;
            mplier_q <= mplier_q >> 1;
        end
    end

endmodule

// File: rtl/param_shift_add_mult.sv
// Sequential shift-add multiplier: IDLE/CALC/DONE control around shift_add_datapath.
// Define MULT_SIGNED_EN to enable two's-complement operands selected by i_SIGNED.
module param_shift_add_mult
    import mult_pkg::*;
#(
    parameter int unsigned WIDTH = 8
) (
    input  logic               i_CLK,
    input  logic               i_RESET,
    input  logic               i_START,
    input  logic [WIDTH-1:0]   i_A,
    input  logic [WIDTH-1:0]   i_B,
    input  logic               i_SIGNED,
    output logic [2*WIDTH-1:0] o_Y,
    output logic               o_DONE,
    output logic               o_BUSY
);

    localparam int unsigned PW = 2 * WIDTH;
    localparam int unsigned CW = cnt_width(WIDTH);

    mult_state_e   state_q;
    mult_state_e   state_nxt;
    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_nxt;
    logic          accept_c;
    logic          last_c;
    logic          busy_nxt;
    logic          done_nxt;
    logic [PW-1:0] y_nxt;
    logic [PW-1:0] prod_c;

    assign accept_c = (state_q != ST_CALC) && i_START;
    assign last_c   = (state_q == ST_CALC) && (cnt_q == CW'(WIDTH - 1));

    shift_add_datapath #(
        .WIDTH(WIDTH)
    ) u_datapath (
        .clk        (i_CLK),
        .rst_n      (i_RESET),
        .load       (accept_c),
        .step       (state_q == ST_CALC),
        .a          (i_A),
        .b          (i_B),
        .signed_mode(i_SIGNED),
        .prod_c     (prod_c)
    );

    // State, counter and registered outputs.
    always_ff @(posedge i_CLK or negedge i_RESET) begin
        if (!i_RESET) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            o_Y     <= '0;
            o_DONE  <= 1'b0;
            o_BUSY  <= 1'b0;
        end else begin
            state_q <= state_nxt;
            cnt_q   <= cnt_nxt;
            o_Y     <= y_nxt;
            o_DONE  <= done_nxt;
            o_BUSY  <= busy_nxt;
        end
    end

    // Next state; DONE accepts a new start exactly like IDLE, CALC ignores it.
    always_comb begin
        state_nxt = ST_IDLE;
        cnt_nxt   = cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (i_START) begin
                    state_nxt = ST_CALC;
                    cnt_nxt   = '0;
                end
            end
            ST_CALC: begin
                cnt_nxt   = cnt_q + 1'b1;
                state_nxt = last_c ? ST_DONE : ST_CALC;
            end
            ST_DONE: begin
                if (i_START) begin
                    state_nxt = ST_CALC;
                    cnt_nxt   = '0;
                end
            end
            default: begin
                state_nxt = ST_IDLE;
                cnt_nxt   = '0;
            end
        endcase
    end

    // Output values for the next cycle; the product is captured only on entry to DONE.
    always_comb begin
        busy_nxt = (state_nxt == ST_CALC);
        done_nxt = (state_nxt == ST_DONE);
        y_nxt    = o_Y;
        if (last_c) begin
            y_nxt = prod_c;
        end
    end

endmodule

// File: tb/tb_param_shift_add_mult.sv
// Bench for param_shift_add_mult: WIDTH=4 latency/result pin plus a WIDTH=8 instance
// checked every cycle against a transaction-level model and directed literal results.
module tb_param_shift_add_mult;

    localparam int WI = 8;
`ifdef MULT_SIGNED_EN
    localparam bit SIGNED_EN = 1'b1;
`else
    localparam bit SIGNED_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start8, s8, start4, s4;
    logic [7:0]  a8, b8;
    logic [3:0]  a4, b4;
    logic [15:0] y8;
    logic [7:0]  y4;
    logic        done8, busy8, done4, busy4;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    param_shift_add_mult #(.WIDTH(8)) u_dut8 (
        .i_CLK(clk), .i_RESET(rst_n), .i_START(start8), .i_A(a8), .i_B(b8),
        .i_SIGNED(s8), .o_Y(y8), .o_DONE(done8), .o_BUSY(busy8)
    );

    param_shift_add_mult #(.WIDTH(4)) u_dut4 (
        .i_CLK(clk), .i_RESET(rst_n), .i_START(start4), .i_A(a4), .i_B(b4),
        .i_SIGNED(s4), .o_Y(y4), .o_DONE(done4), .o_BUSY(busy4)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [15:0] ref_prod(input logic [7:0] a, input logic [7:0] b, input logic s);
        int pa, pb;
        if (SIGNED_EN && s) begin
            pa = int'($signed(a));
            pb = int'($signed(b));
        end else begin
            pa = int'(a);
            pb = int'(b);
        end
        return 16'(pa * pb);
    endfunction

    // Transaction model: phase = edges since acceptance, -1 when nothing is running.
    int          phase;
    logic [15:0] pend, m_y;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            phase <= -1;
            pend  <= '0;
            m_y   <= '0;
        end else if ((phase == -1 || phase == WI) && start8) begin
            phase <= 0;
            pend  <= ref_prod(a8, b8, s8);
        end else if (phase >= 0 && phase < WI) begin
            phase <= phase + 1;
            if (phase == WI - 1) m_y <= pend;
        end else begin
            phase <= -1;
        end
    end

    task automatic compare_loop();
        forever begin
            @(posedge clk);
            #1;
            check("model_y",    32'(y8),    32'(m_y));
            check("model_done", 32'(done8), 32'(phase == WI));
            check("model_busy", 32'(busy8), 32'(phase >= 0 && phase < WI));
        end
    endtask

    task automatic launch(input logic [7:0] a, input logic [7:0] b, input logic s);
        a8 = a; b8 = b; s8 = s; start8 = 1'b1;
    endtask

    // Waits for o_DONE with scrambled operands; pulse_at>0 raises i_START for that one cycle.
    task automatic finish(input string name, input logic [15:0] exp, input int pulse_at);
        int n;
        n = 0;
        while (n < 20) begin
            @(negedge clk);
            n++;
            if (done8) break;
            start8 = (n == pulse_at);
            a8 = 8'($urandom);
            b8 = 8'($urandom);
            s8 = 1'($urandom);
        end
        check({name, "_y"},       32'(y8), 32'(exp));
        check({name, "_latency"}, 32'(n),  32'(WI + 1));
    endtask

    task automatic mul8(input string name, input logic [7:0] a, input logic [7:0] b,
                        input logic s, input logic [15:0] exp);
        @(negedge clk);
        launch(a, b, s);
        finish(name, exp, 0);
    endtask

    initial begin
        int done_first, busy_cnt, done_cnt, n;
        logic [7:0] y4_at_done;
        logic [7:0]  bb_a [3] = '{8'd12, 8'd200, 8'd255};
        logic [7:0]  bb_b [3] = '{8'd13, 8'd3,   8'd1};
        logic [15:0] bb_y [3] = '{16'h009C, 16'h0258, 16'h00FF};

        rst_n = 1'b1;
        start8 = 1'b0; a8 = '0; b8 = '0; s8 = 1'b0;
        start4 = 1'b0; a4 = '0; b4 = '0; s4 = 1'b0;
        fork
            compare_loop();
        join_none
        #1 rst_n = 1'b0;
        #30;
        check("reset_y8",    32'(y8),    32'd0);
        check("reset_done8", 32'(done8), 32'd0);
        check("reset_busy8", 32'(busy8), 32'd0);
        check("reset_y4",    32'(y4),    32'd0);
        #21 rst_n = 1'b1;

        // WIDTH=4: 11 x 14 = 154, busy 4 cycles, done sampled by the 5th edge after acceptance
        @(negedge clk);
        a4 = 4'd11; b4 = 4'd14; start4 = 1'b1;
        done_first = 0; busy_cnt = 0; done_cnt = 0; y4_at_done = '0;
        for (int i = 1; i <= 14; i++) begin
            @(negedge clk);
            if (i == 1) start4 = 1'b0;
            a4 = 4'($urandom); b4 = 4'($urandom);
            if (busy4) busy_cnt++;
            if (done4) begin
                done_cnt++;
                if (done_first == 0) begin
                    done_first = i;
                    y4_at_done = y4;
                end
            end
        end
        check("w4_y",          32'(y4_at_done), 32'h9A);
        check("w4_done_edge",  32'(done_first), 32'd5);
        check("w4_busy_count", 32'(busy_cnt),   32'd4);
        check("w4_done_count", 32'(done_cnt),   32'd1);
        check("w4_y_hold",     32'(y4),         32'h9A);

        // WIDTH=8 unsigned and hold behaviour
        mul8("u_11x14",   8'd11,  8'd14,  1'b0, 16'd154);
        mul8("u_255x255", 8'hFF,  8'hFF,  1'b0, 16'hFE01);
        repeat (6) @(negedge clk);
        check("hold_idle", 32'(y8), 32'hFE01);
        mul8("u_37x0",    8'h37,  8'h00,  1'b0, 16'h0000);

        // Signed mode (unsigned results when the option is not built)
        mul8("s_m128xm128", 8'h80, 8'h80, 1'b1, 16'h4000);
        mul8("s_m3x5",      8'hFD, 8'h05, 1'b1, SIGNED_EN ? 16'hFFF1 : 16'h04F1);
        mul8("u_FDx5",      8'hFD, 8'h05, 1'b0, 16'h04F1);
        mul8("s_m7x127",    8'hF9, 8'h7F, 1'b1, SIGNED_EN ? 16'hFC87 : 16'h7B87);
        mul8("s_m1xm1",     8'hFF, 8'hFF, 1'b1, SIGNED_EN ? 16'h0001 : 16'hFE01);

        // Back-to-back with i_START held high, operands scrambled during CALC
        @(negedge clk);
        launch(bb_a[0], bb_b[0], 1'b0);
        for (int k = 0; k < 3; k++) begin
            n = 0;
            while (n < 20) begin
                @(negedge clk);
                n++;
                if (done8) break;
                a8 = 8'($urandom); b8 = 8'($urandom); s8 = 1'b0;
            end
            check("b2b_y",      32'(y8), 32'(bb_y[k]));
            check("b2b_period", 32'(n),  32'(WI + 1));
            if (k < 2) begin
                a8 = bb_a[k + 1]; b8 = bb_b[k + 1];
            end else begin
                start8 = 1'b0;
            end
        end

        // i_START pulsed mid-CALC is ignored
        @(negedge clk);
        launch(8'd21, 8'd10, 1'b0);
        finish("pulse", 16'd210, 3);
        start8 = 1'b0;
        done_cnt = 0;
        repeat (12) begin
            @(negedge clk);
            if (done8) done_cnt++;
        end
        check("pulse_no_extra_done", 32'(done_cnt), 32'd0);

        // Asynchronous reset during the third CALC cycle aborts the multiply
        @(negedge clk);
        launch(8'd9, 8'd9, 1'b0);
        repeat (3) begin
            @(negedge clk);
            start8 = 1'b0;
        end
        #2 rst_n = 1'b0;
        #1;
        check("abort_y",    32'(y8),    32'd0);
        check("abort_done", 32'(done8), 32'd0);
        check("abort_busy", 32'(busy8), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        launch(8'd6, 8'd7, 1'b0);
        finish("after_reset_6x7", 16'd42, 0);
        start8 = 1'b0;
        repeat (4) @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/param_shift_add_mult.md
PARAM_SHIFT_ADD_MULT -- requirements
Module: param_shift_add_mult

Interface
REQ-001 SHALL have parameter WIDTH, default 8, operand width in bits, legal range 2..32.
REQ-002 SHALL have port i_CLK  input  1  single clock; all state changes on its rising edge.
REQ-003 SHALL have port i_RESET  input  1  asynchronous, active-low reset.
REQ-004 SHALL have port i_START  input  1  request a multiply; sampled on rising edges.
REQ-005 SHALL have port i_A  input  WIDTH  multiplicand; sampled only on the edge that accepts i_START.
REQ-006 SHALL have port i_B  input  WIDTH  multiplier; sampled only on the edge that accepts i_START.
REQ-007 SHALL have port i_SIGNED  input  1  operand mode: 1 = two's complement, 0 = unsigned; sampled with i_A and i_B.
REQ-008 SHALL have port o_Y  output  2*WIDTH  product.
REQ-009 SHALL have port o_DONE  output  1  one-cycle completion strobe.
REQ-010 SHALL have port o_BUSY  output  1  high while a multiply is in progress.

Function
REQ-011 SHALL implement FSM states IDLE, CALC, DONE.
REQ-012 IDLE: i_START=1 at an edge SHALL latch the operands and mode, clear the accumulator, clear the step counter and enter CALC; i_START=0 SHALL stay in IDLE.
REQ-013 CALC SHALL last exactly WIDTH cycles; each cycle SHALL add the shifted multiplicand to the accumulator when the current multiplier bit is 1, shift, and increment the counter.
REQ-014 After the last CALC cycle the FSM SHALL enter DONE; o_DONE SHALL be high for exactly that one cycle, WIDTH+1 rising edges after the accepting edge.
REQ-015 DONE: i_START=1 SHALL be accepted as in IDLE (back-to-back, no idle gap); otherwise the FSM SHALL go to IDLE.
REQ-016 o_BUSY SHALL be high exactly during CALC cycles.
REQ-017 i_START during CALC SHALL be ignored; no queueing.
REQ-018 o_Y SHALL update only on entry to DONE and SHALL hold its value through IDLE and any subsequent CALC, until the next DONE.
REQ-019 Unsigned results SHALL be exact, with no overflow: the full product fits in 2*WIDTH bits.
REQ-020 Operand changes after acceptance SHALL NOT affect the result.

Reset
REQ-021 When i_RESET is low, the block SHALL go to IDLE immediately, with o_Y=0, o_DONE=0, o_BUSY=0, and the counter, accumulator and latched operands all 0.
REQ-022 Reset asserted mid-CALC SHALL abort the operation; no o_DONE SHALL follow.
REQ-023 After reset deasserts, the first rising edge SHALL be able to accept i_START.

Configuration
REQ-024 Macro MULT_SIGNED_EN defined: when i_SIGNED=1, the block SHALL multiply operand magnitudes and, if the operand signs differ, two's-complement negate the 2*WIDTH-bit result at DONE entry.
REQ-025 MULT_SIGNED_EN defined: the most-negative operand SHALL be handled correctly, because its magnitude is treated as a WIDTH-bit unsigned value.
REQ-026 MULT_SIGNED_EN defined: latency SHALL be unchanged by the signed mode.
REQ-027 MULT_SIGNED_EN undefined: i_SIGNED SHALL be present but ignored, all multiplies SHALL be unsigned, and no sign logic SHALL be synthesised.

Structure
REQ-028 A shared package mult_pkg SHALL hold the FSM state encoding (IDLE/CALC/DONE) and the counter-width function clog2(WIDTH+1).
REQ-029 One sub-module, shift_add_datapath, SHALL contain the accumulator, shifted-multiplicand and multiplier registers plus the adder; FSM and handshake SHALL stay in the top module.

Verification
REQ-030 WIDTH=4, reset low for 50 ns, then high; i_A=11, i_B=14, i_START=1 -> o_DONE on the 5th edge after acceptance, o_Y=154 (0x9A), o_BUSY high for 4 cycles.
REQ-031 WIDTH=8, unsigned, 255x255 -> o_Y=0xFE01; 0x37 then 0 -> o_Y=0; o_Y holds its value in IDLE until the next DONE.
REQ-032 WIDTH=8, MULT_SIGNED_EN, i_SIGNED=1: -128x-128 -> 0x4000; -3x5 -> 0xFFF1; i_SIGNED=0 with 0xFD x 5 -> 0x04F1.
REQ-033 i_START held high continuously, WIDTH=8 -> o_DONE every 9 cycles; toggling i_A/i_B during CALC leaves each result unchanged; i_START pulsed mid-CALC is ignored.
REQ-034 Reset asserted in CALC step 3 -> outputs zero asynchronously, no o_DONE; the next multiply, 6x7 -> 42.
